// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the fetch stage
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] PC_INCR           = 32'd4;

    // Sequential successor of a fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory request/response bundle
interface instruction_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry buffer parking {pc+4, word} while the stage is stalled
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic        full
);

    // Capture on load, drop on clear; clear wins because a flush supersedes a parked word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage with one outstanding imem request, stall hold and branch redirect
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master imem,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    output logic [31:0]         PC_out,
    output logic [31:0]         instruction_out,
    output logic                valid_out
);

    fetch_state_t state, state_next;
    logic [31:0]  pc;
    logic [31:0]  redirect;
    logic [63:0]  buf_data;
    logic         buf_full;
    logic         req;
    logic         pc_load_inc, pc_load_tgt, pc_load_redir, redir_load;
    logic         buf_load, buf_clear;
    logic         out_fetch, out_buf, out_bubble;

    assign imem.req  = req;
    assign imem.addr = pc;

    fetch_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .din   ({next_seq_pc(pc), imem.rdata}),
        .dout  (buf_data),
        .full  (buf_full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: a branch without ack must wait out the in-flight request in DRAIN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = REQ;
            REQ: begin
                if (branch_taken)          state_next = imem.ack ? REQ : DRAIN;
                else if (imem.ack && stall) state_next = HOLD;
            end
            HOLD:  if (branch_taken || !stall) state_next = REQ;
            DRAIN: if (imem.ack) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    // Control decode: request strobe, pc source, hold-buffer and output-register actions.
    always_comb begin
        req           = (state == REQ) || (state == DRAIN);
        pc_load_inc   = 1'b0;
        pc_load_tgt   = 1'b0;
        pc_load_redir = 1'b0;
        redir_load    = 1'b0;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        out_fetch     = 1'b0;
        out_buf       = 1'b0;
        case (state)
            IDLE: pc_load_tgt = branch_taken;
            REQ: begin
                if (branch_taken) begin
                    pc_load_tgt = imem.ack;
                    redir_load  = !imem.ack;
                end else if (imem.ack) begin
                    pc_load_inc = 1'b1;
                    buf_load    = stall;
                    out_fetch   = !stall;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_load_tgt = 1'b1;
                    buf_clear   = 1'b1;
                end else if (!stall && buf_full) begin
                    out_buf   = 1'b1;
                    buf_clear = 1'b1;
                end
            end
            DRAIN: begin
                redir_load = branch_taken;
                if (imem.ack) begin
                    pc_load_tgt   = branch_taken;
                    pc_load_redir = !branch_taken;
                end
            end
            default: ;
        endcase
        // Flushes always bubble; otherwise an unstalled cycle with nothing to deliver bubbles too.
        out_bubble = branch_taken ||
                     (!stall && !out_fetch && !out_buf && (state != IDLE));
    end

    // Program counter and redirect register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            redirect <= '0;
        end else begin
            if (pc_load_tgt)        pc <= branch_target;
            else if (pc_load_redir) pc <= redirect;
            else if (pc_load_inc)   pc <= next_seq_pc(pc);
            if (redir_load)         redirect <= branch_target;
        end
    end

    // IF/ID-facing output registers; they hold whenever no action is selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_out          <= '0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else if (out_bubble) begin
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else if (out_fetch) begin
            PC_out          <= next_seq_pc(pc);
            instruction_out <= imem.rdata;
            valid_out       <= 1'b1;
        end else if (out_buf) begin
            {PC_out, instruction_out} <= buf_data;
            valid_out                 <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized checks of instruction_fetch against a reference model
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] PC_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic        ack_drv = 1'b0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_word = '0;
    logic [31:0] key = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    instruction_fetch_if ifc ();
    assign ifc.ack   = ack_drv;
    assign ifc.rdata = use_fixed ? fixed_word : (ifc.addr ^ key);

    instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (ifc),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    // Reference model: fetch is "active" once out of reset; a parked word blocks new requests;
    // a pending redirect means the in-flight request must be acknowledged and thrown away.
    bit          m_active;
    logic [63:0] m_held[$];
    logic [31:0] m_redir[$];
    logic [31:0] m_pc, m_pc_out, m_instr;
    logic        m_valid;

    function automatic void model_reset();
        m_active = 1'b0;
        m_held.delete();
        m_redir.delete();
        m_pc     = RST_PC;
        m_pc_out = '0;
        m_instr  = NOP;
        m_valid  = 1'b0;
    endfunction

    function automatic bit model_req();
        return m_active && (m_held.size() == 0);
    endfunction

    function automatic void model_step(input bit st, input bit br, input logic [31:0] tgt,
                                       input bit ak, input logic [31:0] word);
        bit holding, draining, accepted;
        logic [31:0] pc4;
        holding  = m_held.size() != 0;
        draining = m_redir.size() != 0;
        accepted = model_req() && ak;
        if (!m_active) begin
            m_active = 1'b1;
            if (br) begin
                m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
            end
            return;
        end
        if (br) begin
            m_instr = NOP; m_valid = 1'b0;
            m_held.delete();
            if (holding || accepted) begin
                m_pc = tgt;
                m_redir.delete();
            end else begin
                m_redir.delete();
                m_redir.push_back(tgt);
            end
        end else if (draining) begin
            if (accepted) begin
                m_pc = m_redir[0];
                m_redir.delete();
            end
            if (!st) begin m_instr = NOP; m_valid = 1'b0; end
        end else if (holding) begin
            if (!st) begin
                {m_pc_out, m_instr} = m_held[0];
                m_valid = 1'b1;
                m_held.delete();
            end
        end else if (accepted) begin
            pc4 = m_pc + 32'd4;
            if (st) m_held.push_back({pc4, word});
            else begin m_pc_out = pc4; m_instr = word; m_valid = 1'b1; end
            m_pc = pc4;
        end else if (!st) begin
            m_instr = NOP; m_valid = 1'b0;
        end
    endfunction

    task automatic check(input string tag);
        n_checks++;
        assert (PC_out === m_pc_out) else begin
            n_fail++; $error("FAIL %s PC_out got %h want %h", tag, PC_out, m_pc_out);
        end
        n_checks++;
        assert (instruction_out === m_instr) else begin
            n_fail++; $error("FAIL %s instruction_out got %h want %h", tag, instruction_out, m_instr);
        end
        n_checks++;
        assert (valid_out === m_valid) else begin
            n_fail++; $error("FAIL %s valid_out got %b want %b", tag, valid_out, m_valid);
        end
        n_checks++;
        assert (ifc.req === model_req()) else begin
            n_fail++; $error("FAIL %s imem_req got %b want %b", tag, ifc.req, model_req());
        end
        if (model_req()) begin
            n_checks++;
            assert (ifc.addr === m_pc) else begin
                n_fail++; $error("FAIL %s imem_addr got %h want %h", tag, ifc.addr, m_pc);
            end
        end
    endtask

    task automatic expect32(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++; $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick(input string tag, input bit st, input bit br,
                        input logic [31:0] tgt, input bit ak);
        logic [31:0] word;
        stall = st; branch_taken = br; branch_target = tgt; ack_drv = ak;
        word = use_fixed ? fixed_word : (m_pc ^ key);
        model_step(st, br, tgt, ak, word);
        @(posedge clk);
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset");
        rst = 1'b0;

        // Continuous ack, rdata = address: consecutive PC_out 4, 8, 12.
        tick("boot", 1'b0, 1'b0, 32'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick("a_wait", 1'b0, 1'b0, 32'h0, 1'b1);
            if (valid_out === 1'b1) found = 1'b1;
        end
        expect32("a_first_valid", {31'b0, found}, 32'd1);
        expect32("a_pc4", PC_out, 32'd4);
        expect32("a_instr0", instruction_out, 32'h0);
        tick("a_seq", 1'b0, 1'b0, 32'h0, 1'b1);
        expect32("a_pc8", PC_out, 32'd8);
        tick("a_seq", 1'b0, 1'b0, 32'h0, 1'b1);
        expect32("a_pc12", PC_out, 32'd12);

        // Ack every third cycle: valid 1,0,0 pattern with NOP bubbles.
        for (int i = 0; i < 9; i++) begin
            tick("b_ack3", 1'b0, 1'b0, 32'h0, (i % 3) == 0);
            expect32("b_valid", {31'b0, valid_out}, {31'b0, (i % 3) == 0});
        end

        // Stall on the ack cycle, held four cycles, then the parked word emerges.
        use_fixed = 1'b1; fixed_word = 32'h8C01_0004;
        tick("c_ack", 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick("c_hold", 1'b1, 1'b0, 32'h0, 1'b0);
            expect32("c_req_low", {31'b0, ifc.req}, 32'd0);
        end
        tick("c_rel", 1'b0, 1'b0, 32'h0, 1'b0);
        expect32("c_word", instruction_out, 32'h8C01_0004);
        expect32("c_valid", {31'b0, valid_out}, 32'd1);
        use_fixed = 1'b0;

        // Branch while stalled in HOLD.
        tick("d_ack", 1'b1, 1'b0, 32'h0, 1'b1);
        tick("d_br", 1'b1, 1'b1, 32'h0000_0040, 1'b0);
        expect32("d_valid", {31'b0, valid_out}, 32'd0);
        expect32("d_nop", instruction_out, NOP);
        expect32("d_addr", ifc.addr, 32'h0000_0040);

        // Branch to 0x80 while the 0x10 request is pending; ack two cycles later.
        tick("e_go10", 1'b0, 1'b1, 32'h0000_0010, 1'b1);
        tick("e_br80", 1'b0, 1'b1, 32'h0000_0080, 1'b0);
        expect32("e_addr_hold1", ifc.addr, 32'h0000_0010);
        tick("e_wait", 1'b0, 1'b0, 32'h0, 1'b0);
        expect32("e_addr_hold2", ifc.addr, 32'h0000_0010);
        tick("e_ack", 1'b0, 1'b0, 32'h0, 1'b1);
        expect32("e_discard", {31'b0, valid_out}, 32'd0);
        expect32("e_addr80", ifc.addr, 32'h0000_0080);
        tick("e_fetch", 1'b0, 1'b0, 32'h0, 1'b1);
        expect32("e_pc84", PC_out, 32'h0000_0084);
        expect32("e_word80", instruction_out, 32'h0000_0080);

        // PC wraps modulo 2^32.
        tick("w_br", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        tick("w_fetch", 1'b0, 1'b0, 32'h0, 1'b1);
        expect32("w_pc_out", PC_out, 32'h0);
        expect32("w_addr", ifc.addr, 32'h0);

        // Reset pulsed mid-DRAIN with a late ack afterwards.
        tick("f_br", 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        #2 rst = 1'b1;
        #1 model_reset();
        check("f_rst_async");
        ack_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("f_rst_held");
        rst = 1'b0;
        tick("f_late_ack", 1'b0, 1'b0, 32'h0, 1'b1);
        expect32("f_addr_reset", ifc.addr, RST_PC);
        tick("f_fetch", 1'b0, 1'b0, 32'h0, 1'b1);
        expect32("f_pc4", PC_out, RST_PC + 32'd4);

        // Randomized traffic against the model.
        key = $urandom();
        for (int i = 0; i < 400; i++) begin
            tick("rand",
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom(),
                 $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
